tile_cov_walker: RTL and testbench

Consumes the per-row 32-pixel coverage mask from the tile inside-triangle evaluator and turns it into a stream of individual covered-pixel fragments for the downstream shading/ISP stage. For one 32x32 tile it steps the evaluator through all 32 rows by driving the pixel coordinates. It captures each row mask, then emits one (x,y) fragment per set bit over a valid/ready handshake. Empty rows are skipped.

---
 rtl/tile_cov_walker_pkg.sv | 32 +++
 rtl/tile_cov_walker_enc.sv | 34 +++
 rtl/tile_cov_walker.sv | 184 ++++++++++++++++++
 tb/tb_tile_cov_walker.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_cov_walker_pkg.sv
// Shared definitions for the tile coverage walker.
// Holds the tile geometry, the walker state encoding, the fragment record
// and a small mask helper used by the walker datapath.
package tile_cov_walker_pkg;

    localparam int TILE_DIM   = 32;
    localparam int TILE_SHIFT = 5;
    localparam int COORD_W    = 11;

    // 32 rows x 32 pixels is the most one tile can ever produce.
    localparam logic [10:0] FRAG_COUNT_MAX = 11'd1024;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        CAPTURE = 3'd2,
        WALK    = 3'd3,
        NEXT    = 3'd4
    } walk_state_e;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        eol;
    } frag_t;

    // Drops the lowest set bit of a row mask (the fragment just handed out).
    function automatic logic [31:0] clear_lowest(input logic [31:0] m);
        return m & (m - 32'd1);
    endfunction

endpackage

// File: rtl/tile_cov_walker_enc.sv
// cov_lsb_enc: combinational lowest-set-bit encoder for a 32-bit row mask.
// Ports:
//   vec    - row coverage mask
//   idx    - index of the lowest set bit (0 when vec is empty)
//   any    - at least one bit set
//   single - exactly one bit set
module cov_lsb_enc
    import tile_cov_walker_pkg::*;
(
    input  logic [31:0] vec,
    output logic [4:0]  idx,
    output logic        any,
    output logic        single
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = 5'd0;
        for (int i = TILE_DIM - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 5'(i);
            end else begin
                idx = idx;
            end
        end
    end

    // A mask with its lowest bit removed is empty only if one bit was set.
    always_comb begin
        any    = |vec;
        single = any && (clear_lowest(vec) == 32'd0);
    end

endmodule

// File: rtl/tile_cov_walker.sv
// tile_cov_walker: steps the coverage evaluator through the 32 rows of a
// 32x32 tile and converts each row mask into a stream of (x,y) fragments.
// Ports:
//   clock, reset            - clock, asynchronous active-high reset
//   tile_start, tile_abort  - begin a tile (IDLE only) / return to IDLE
//   tile_x, tile_y          - tile indices, latched on an accepted start
//   x_ps, y_ps              - pixel coordinates driven to the evaluator
//   inTri                   - row coverage mask from the evaluator
//   frag_valid/ready        - fragment handshake
//   frag_x, frag_y, frag_eol- fragment position, last-in-row flag
//   busy, tile_done         - activity level, normal-completion pulse
//   frag_count              - fragments accepted in the current tile
module tile_cov_walker
    import tile_cov_walker_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
)(
    input  logic        clock,
    input  logic        reset,
    input  logic        tile_start,
    input  logic        tile_abort,
    input  logic [5:0]  tile_x,
    input  logic [5:0]  tile_y,
    output logic [10:0] x_ps,
    output logic [10:0] y_ps,
    input  logic [31:0] inTri,
    output logic        frag_valid,
    input  logic        frag_ready,
    output logic [10:0] frag_x,
    output logic [10:0] frag_y,
    output logic        frag_eol,
    output logic        busy,
    output logic        tile_done,
    output logic [10:0] frag_count
);

    localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYCLES - 1);

    walk_state_e state_r, state_nxt_s;
    logic [4:0]  row_r;
    logic [2:0]  settle_cnt_r;
    logic [31:0] mask_r, mask_nxt_s;
    logic [10:0] x_ps_r, y_ps_r, frag_count_r;
    frag_t       frag_r, frag_nxt_s;
    logic        frag_valid_r, frag_valid_nxt_s;
    logic        busy_r, busy_nxt_s;
    logic        tile_done_r, tile_done_nxt_s;
    logic        xfer_s, start_ok_s, last_row_s;
    logic [4:0]  enc_idx_s;
    logic        enc_any_s, enc_single_s;

    assign xfer_s     = frag_valid_r && frag_ready;
    assign start_ok_s = (state_r == IDLE) && tile_start && !tile_abort;
    assign last_row_s = (row_r == 5'd31);

    // The fragment outputs are registered, so the encoder looks at the mask
    // as it will be after this edge rather than the current one.
    cov_lsb_enc u_enc (
        .vec    (mask_nxt_s),
        .idx    (enc_idx_s),
        .any    (enc_any_s),
        .single (enc_single_s)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_nxt_s = state_r;
        if (tile_abort) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    if (tile_start) state_nxt_s = SETTLE;
                         else            state_nxt_s = IDLE;
                SETTLE:  if (settle_cnt_r == SETTLE_LAST) state_nxt_s = CAPTURE;
                         else                             state_nxt_s = SETTLE;
                CAPTURE: if (inTri == 32'd0) state_nxt_s = NEXT;
                         else                state_nxt_s = WALK;
                WALK:    if (xfer_s && frag_r.eol) state_nxt_s = NEXT;
                         else                      state_nxt_s = WALK;
                NEXT:    if (last_row_s) state_nxt_s = IDLE;
                         else            state_nxt_s = SETTLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Mask update: load on capture, retire the lowest bit on each transfer.
    always_comb begin
        mask_nxt_s = mask_r;
        if (tile_abort) begin
            mask_nxt_s = 32'd0;
        end else if (state_r == CAPTURE) begin
            mask_nxt_s = inTri;
        end else if (xfer_s) begin
            mask_nxt_s = clear_lowest(mask_r);
        end else begin
            mask_nxt_s = mask_r;
        end
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        frag_valid_nxt_s = 1'b0;
        frag_nxt_s       = '0;
        if (state_nxt_s == WALK) begin
            frag_valid_nxt_s = enc_any_s;
            frag_nxt_s.x     = {x_ps_r[COORD_W-1:TILE_SHIFT], enc_idx_s};
            frag_nxt_s.y     = y_ps_r;
            frag_nxt_s.eol   = enc_single_s;
        end else begin
            frag_valid_nxt_s = 1'b0;
            frag_nxt_s       = '0;
        end
        tile_done_nxt_s = (state_r == NEXT) && last_row_s && !tile_abort;
        busy_nxt_s      = (state_nxt_s != IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_r        <= 5'd0;
            settle_cnt_r <= 3'd0;
            mask_r       <= 32'd0;
            x_ps_r       <= 11'd0;
            y_ps_r       <= 11'd0;
            frag_count_r <= 11'd0;
            frag_r       <= '0;
            frag_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            tile_done_r  <= 1'b0;
        end else begin
            mask_r       <= mask_nxt_s;
            frag_r       <= frag_nxt_s;
            frag_valid_r <= frag_valid_nxt_s;
            busy_r       <= busy_nxt_s;
            tile_done_r  <= tile_done_nxt_s;
            // Restarts from zero on every entry into SETTLE.
            if (state_r == SETTLE) begin
                settle_cnt_r <= settle_cnt_r + 3'd1;
            end else begin
                settle_cnt_r <= 3'd0;
            end
            if (start_ok_s) begin
                x_ps_r       <= {tile_x, 5'd0};
                y_ps_r       <= {tile_y, 5'd0};
                row_r        <= 5'd0;
                frag_count_r <= 11'd0;
            end else begin
                if (xfer_s && !tile_abort && (frag_count_r != FRAG_COUNT_MAX)) begin
                    frag_count_r <= frag_count_r + 11'd1;
                end else begin
                    frag_count_r <= frag_count_r;
                end
                if ((state_r == NEXT) && !last_row_s && !tile_abort) begin
                    row_r  <= row_r + 5'd1;
                    y_ps_r <= {y_ps_r[COORD_W-1:TILE_SHIFT], row_r + 5'd1};
                end else begin
                    row_r  <= row_r;
                    y_ps_r <= y_ps_r;
                end
            end
        end
    end

    assign x_ps       = x_ps_r;
    assign y_ps       = y_ps_r;
    assign frag_valid = frag_valid_r;
    assign frag_x     = frag_r.x;
    assign frag_y     = frag_r.y;
    assign frag_eol   = frag_r.eol;
    assign busy       = busy_r;
    assign tile_done  = tile_done_r;
    assign frag_count = frag_count_r;

endmodule

// File: tb/tb_tile_cov_walker.sv
// Self-checking bench for tile_cov_walker. The evaluator is modelled as a
// per-row mask table indexed by y_ps; the expected fragment stream is built
// from that table by walking rows and bits in order.
module tb_tile_cov_walker;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tile_start = 1'b0;
    logic        tile_abort = 1'b0;
    logic [5:0]  tile_x = 6'd0;
    logic [5:0]  tile_y = 6'd0;
    logic [10:0] x_ps, y_ps, frag_x, frag_y, frag_count;
    logic [31:0] inTri;
    logic        frag_valid, frag_eol, busy, tile_done;
    logic        frag_ready = 1'b0;

    logic [31:0] row_mask [32];

    typedef struct {
        int x;
        int y;
        int eol;
    } exp_frag_t;

    exp_frag_t exp_q[$];

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;
    int done_cnt = 0;
    int cyc_n = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int last_xfer_cyc = 0;
    int ready_mode = 0;
    bit ready_phase = 1'b0;

    tile_cov_walker #(.SETTLE_CYCLES(1)) dut (
        .clock      (clock),
        .reset      (reset),
        .tile_start (tile_start),
        .tile_abort (tile_abort),
        .tile_x     (tile_x),
        .tile_y     (tile_y),
        .x_ps       (x_ps),
        .y_ps       (y_ps),
        .inTri      (inTri),
        .frag_valid (frag_valid),
        .frag_ready (frag_ready),
        .frag_x     (frag_x),
        .frag_y     (frag_y),
        .frag_eol   (frag_eol),
        .busy       (busy),
        .tile_done  (tile_done),
        .frag_count (frag_count)
    );

    always #5 clock = ~clock;

    assign inTri = row_mask[y_ps[4:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_rows(input logic [31:0] m);
        for (int r = 0; r < 32; r++) row_mask[r] = m;
    endtask

    task automatic build_model(input int tx, input int ty);
        exp_frag_t f;
        int hi;
        exp_q.delete();
        for (int r = 0; r < 32; r++) begin
            hi = -1;
            for (int b = 0; b < 32; b++) if (row_mask[r][b]) hi = b;
            for (int b = 0; b < 32; b++) begin
                if (row_mask[r][b]) begin
                    f.x = tx * 32 + b;
                    f.y = ty * 32 + r;
                    f.eol = (b == hi) ? 1 : 0;
                    exp_q.push_back(f);
                end
            end
        end
    endtask

    task automatic pulse_start(input int tx, input int ty);
        @(posedge clock); #1;
        tile_x = 6'(tx);
        tile_y = 6'(ty);
        tile_start = 1'b1;
        @(posedge clock); #1;
        tile_start = 1'b0;
    endtask

    task automatic start_tile(input int tx, input int ty);
        build_model(tx, ty);
        exp_cnt = 0;
        pulse_start(tx, ty);
    endtask

    task automatic wait_done(input int done0, input string name);
        int n;
        n = 0;
        while (done_cnt == done0 && n < 5000) begin
            @(posedge clock);
            n++;
        end
        chk(name, 32'(done_cnt != done0), 32'd1);
    endtask

    task automatic end_checks(input int done0, input int nfrag, input string name);
        repeat (3) @(posedge clock);
        #1;
        chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_done_once"}, 32'(done_cnt - done0), 32'd1);
        chk({name, "_frag_count"}, 32'(frag_count), 32'(nfrag));
        chk({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Downstream ready pattern, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clock); #1;
            ready_phase = ~ready_phase;
            case (ready_mode)
                0:       frag_ready = 1'b1;
                1:       frag_ready = ready_phase;
                default: frag_ready = 1'b0;
            endcase
        end
    end

    // Compare process: checks every handshake and every stalled cycle.
    initial begin
        exp_frag_t e;
        bit prev_stall;
        logic [10:0] px, py;
        logic pe;
        prev_stall = 1'b0;
        px = 11'd0;
        py = 11'd0;
        pe = 1'b0;
        forever begin
            @(negedge clock);
            cyc_n++;
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (tile_start) start_cyc = cyc_n;
                if (tile_done) begin
                    done_cnt++;
                    done_cyc = cyc_n;
                end
                if (prev_stall) begin
                    chk("stall_valid", 32'(frag_valid), 32'd1);
                    chk("stall_x", 32'(frag_x), 32'(px));
                    chk("stall_y", 32'(frag_y), 32'(py));
                    chk("stall_eol", 32'(frag_eol), 32'(pe));
                end
                if (frag_valid && exp_q.size() == 0) begin
                    chk("spurious_valid", 32'd1, 32'd0);
                end else if (frag_valid && frag_ready) begin
                    e = exp_q.pop_front();
                    chk("frag_x", 32'(frag_x), e.x);
                    chk("frag_y", 32'(frag_y), e.y);
                    chk("frag_eol", 32'(frag_eol), e.eol);
                    chk("frag_count_run", 32'(frag_count), exp_cnt);
                    exp_cnt++;
                    last_xfer_cyc = cyc_n;
                end
                prev_stall = frag_valid && !frag_ready && !tile_abort;
                px = frag_x;
                py = frag_y;
                pe = frag_eol;
            end
        end
    end

    initial begin
        int d0;
        int n;
        set_rows(32'd0);

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", 32'(frag_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(tile_done), 32'd0);
        chk("rst_count", 32'(frag_count), 32'd0);
        chk("rst_xy_ps", 32'({x_ps, y_ps}), 32'd0);
        chk("rst_frag", 32'({frag_x, frag_y, frag_eol}), 32'd0);
        reset = 1'b0;

        // Two pixels per row, full-speed downstream.
        set_rows(32'h0000_0005);
        ready_mode = 0;
        d0 = done_cnt;
        start_tile(3, 2);
        chk("model_len", 32'(exp_q.size()), 32'd64);
        chk("model_x0", exp_q[0].x, 32'd96);
        chk("model_y0", exp_q[0].y, 32'd64);
        chk("model_eol0", exp_q[0].eol, 32'd0);
        chk("model_x1", exp_q[1].x, 32'd98);
        chk("model_eol1", exp_q[1].eol, 32'd1);
        chk("model_y63", exp_q[63].y, 32'd95);
        wait_done(d0, "t1_done");
        end_checks(d0, 64, "t1");

        // Only the very last pixel of the tile is covered.
        set_rows(32'd0);
        row_mask[31] = 32'h8000_0000;
        d0 = done_cnt;
        start_tile(5, 7);
        chk("model_single_x", exp_q[0].x, 32'd191);
        chk("model_single_y", exp_q[0].y, 32'd255);
        wait_done(d0, "t2_done");
        chk("t2_done_lag", 32'(done_cyc - last_xfer_cyc), 32'd2);
        end_checks(d0, 1, "t2");

        // Fully covered tile at the far corner with a stalling consumer.
        set_rows(32'hFFFF_FFFF);
        ready_mode = 1;
        d0 = done_cnt;
        start_tile(63, 63);
        chk("model_full_len", 32'(exp_q.size()), 32'd1024);
        chk("model_full_last_x", exp_q[1023].x, 32'd2047);
        wait_done(d0, "t3_done");
        end_checks(d0, 1024, "t3");

        // Empty tile: only settle/capture/next per row.
        set_rows(32'd0);
        ready_mode = 0;
        d0 = done_cnt;
        start_tile(10, 20);
        wait_done(d0, "t4_done");
        chk("t4_latency", 32'(done_cyc - start_cyc), 32'd97);
        end_checks(d0, 0, "t4");

        // Abort while a fragment is stalled.
        set_rows(32'hFFFF_FFFF);
        ready_mode = 1;
        d0 = done_cnt;
        start_tile(1, 1);
        n = 0;
        while (exp_cnt < 3 && n < 200) begin
            @(posedge clock);
            n++;
        end
        chk("t5_some_xfers", 32'(exp_cnt >= 3), 32'd1);
        @(posedge clock); #2;
        ready_mode = 2;
        repeat (4) @(posedge clock);
        #1;
        chk("t5_pending", 32'(frag_valid), 32'd1);
        tile_abort = 1'b1;
        @(posedge clock); #1;
        tile_abort = 1'b0;
        chk("t5_abort_valid", 32'(frag_valid), 32'd0);
        chk("t5_abort_busy", 32'(busy), 32'd0);
        chk("t5_count_held", 32'(frag_count), exp_cnt);
        exp_q.delete();
        repeat (3) @(posedge clock);
        #1;
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);

        // Clean tile after the abort, one pixel per row on the diagonal.
        for (int r = 0; r < 32; r++) row_mask[r] = 32'd1 << r;
        ready_mode = 0;
        d0 = done_cnt;
        start_tile(1, 4);
        wait_done(d0, "t5b_done");
        end_checks(d0, 32, "t5b");

        // A start while busy must not disturb the running tile.
        set_rows(32'h0000_0003);
        d0 = done_cnt;
        start_tile(2, 1);
        repeat (10) @(posedge clock);
        pulse_start(9, 9);
        wait_done(d0, "t6_done");
        end_checks(d0, 64, "t6");

        // Asynchronous reset in the middle of a row.
        set_rows(32'h0000_00F0);
        ready_mode = 1;
        start_tile(6, 6);
        n = 0;
        while (exp_cnt < 5 && n < 200) begin
            @(posedge clock);
            n++;
        end
        @(posedge clock); #3;
        reset = 1'b1;
        #1;
        chk("t7_rst_valid", 32'(frag_valid), 32'd0);
        chk("t7_rst_busy", 32'(busy), 32'd0);
        chk("t7_rst_count", 32'(frag_count), 32'd0);
        chk("t7_rst_ps", 32'({x_ps, y_ps}), 32'd0);
        chk("t7_rst_frag", 32'({frag_x, frag_y, frag_eol}), 32'd0);
        exp_q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("t7_after_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
